alu_result_arbiter: RTL

//  Downstream of the multiplier and adder/subtractor: captures each unit's single-cycle result pulse into a
//  one-entry slot, arbitrates round-robin between the slots and writes one result per grant into FIFO_out.

---
 rtl/alu_pkg.sv | 18 +
 rtl/d_ff_async_en.sv | 18 +
 rtl/result_capture_slot.sv | 29 ++
 rtl/alu_result_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU result arbiter: FSM states, grant source codes and default widths.
package alu_pkg;

   localparam int DEF_DATA_SIZE = 32;
   localparam int DEF_ID_SIZE   = 4;
   localparam int DEF_CNT_SIZE  = 16;
   localparam int RES_SIZE      = DEF_DATA_SIZE + 1 + DEF_ID_SIZE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_MUL = 2'd1,
      WR_AS  = 2'd2
   } state_t;

   localparam logic SRC_MUL = 1'b0;
   localparam logic SRC_AS  = 1'b1;

endpackage

// File: rtl/d_ff_async_en.sv
// Generic enabled register with asynchronous active-high reset to a parameterised value.
module d_ff_async_en #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/result_capture_slot.sv
// One-entry holding slot for a producer's result pulse; flags an overwrite of a still-pending result.
module result_capture_slot #(
   parameter int W = 37
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  logic [W-1:0] capture_data,
   input  logic         clear,
   output logic         pend,
   output logic [W-1:0] data,
   output logic         ovf
);

   // A capture in the same cycle as the clear wins: the slot stays pending with the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 1'b0;
         data <= '0;
      end else begin
         if (capture)    pend <= 1'b1;
         else if (clear) pend <= 1'b0;
         if (capture)    data <= capture_data;
      end
   end

   assign ovf = capture & pend & ~clear;

endmodule

// File: rtl/alu_result_arbiter.sv
// Captures multiplier and add/sub result pulses, arbitrates round-robin and writes one result per
// grant into FIFO_out, returning a written pulse to the producing unit.
module alu_result_arbiter
   import alu_pkg::*;
#(
   parameter  int DATA_SIZE = DEF_DATA_SIZE,
   parameter  int ID_SIZE   = DEF_ID_SIZE,
   parameter  int CNT_SIZE  = DEF_CNT_SIZE,
   localparam int RW        = DATA_SIZE + 1 + ID_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m_valid_res,
   input  logic [RW-1:0]       result_mul,
   input  logic                as_valid_res,
   input  logic [RW-1:0]       result_as,
   input  logic                fifo_full,
   output logic                fifo_wr_en,
   output logic [RW-1:0]       fifo_wr_data,
   output logic                mul_written,
   output logic                as_written,
   output logic                ready_f_res_m,
   output logic                ready_f_res_as,
   output logic                ovf_err,
   output logic [CNT_SIZE-1:0] res_count
);

   logic          pend_mul, pend_as, ovf_mul, ovf_as;
   logic [RW-1:0] data_mul, data_as;
   logic [1:0]    state_q;
   state_t        state, state_d;
   logic          last_grant;
   logic          wr_mul, wr_as, wr_any;

   assign state  = state_t'(state_q);
   assign wr_mul = (state == WR_MUL);
   assign wr_as  = (state == WR_AS);
   assign wr_any = wr_mul | wr_as;

   result_capture_slot #(.W(RW)) u_slot_mul (
      .clk(clk), .rst(rst), .capture(m_valid_res), .capture_data(result_mul),
      .clear(wr_mul), .pend(pend_mul), .data(data_mul), .ovf(ovf_mul)
   );

   result_capture_slot #(.W(RW)) u_slot_as (
      .clk(clk), .rst(rst), .capture(as_valid_res), .capture_data(result_as),
      .clear(wr_as), .pend(pend_as), .data(data_as), .ovf(ovf_as)
   );

   // Write states always fall back to IDLE, so writes are at least two cycles apart.
   always_comb begin
      state_d = IDLE;
      if (state == IDLE && !fifo_full) begin
         if (pend_mul && pend_as) state_d = (last_grant == SRC_AS) ? WR_MUL : WR_AS;
         else if (pend_mul)       state_d = WR_MUL;
         else if (pend_as)        state_d = WR_AS;
      end
   end

   d_ff_async_en #(.W(2), .RST_VAL(IDLE)) u_state_ff (
      .clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_q)
   );

   d_ff_async_en #(.W(1), .RST_VAL(SRC_AS)) u_last_ff (
      .clk(clk), .rst(rst), .en(wr_any), .d(wr_mul ? SRC_MUL : SRC_AS), .q(last_grant)
   );

   d_ff_async_en #(.W(CNT_SIZE), .RST_VAL('0)) u_count_ff (
      .clk(clk), .rst(rst), .en(wr_any), .d(res_count + 1'b1), .q(res_count)
   );

   d_ff_async_en #(.W(1), .RST_VAL(1'b0)) u_ovf_ff (
      .clk(clk), .rst(rst), .en(ovf_mul | ovf_as), .d(1'b1), .q(ovf_err)
   );

   assign fifo_wr_en     = wr_any;
   assign fifo_wr_data   = wr_mul ? data_mul : (wr_as ? data_as : '0);
   assign mul_written    = wr_mul;
   assign as_written     = wr_as;
   assign ready_f_res_m  = ~rst & ~pend_mul & ~fifo_full;
   assign ready_f_res_as = ~rst & ~pend_as & ~fifo_full;

endmodule
